pool_3: RTL
===========

POOL_3 -- requirements
Module: pool_3

Interface
REQ-001 Parameter IN_SIZE, default 24, input image width and height in pixels.
REQ-002 Parameter CH, default 16, channels per pixel.
REQ-003 Parameter DW, default 8, bits per channel, unsigned (post-ReLU, non-negative).
REQ-004 clk  input  1  single clock; all state changes on rising edge.
REQ-005 rst  input  1  asynchronous, active-low reset.
REQ-006 conv_start  input  1  one-cycle start pulse for a new image; shared with downstream layer-3 input control.
REQ-007 in_valid  input  1  in_data carries one ReLU pixel this cycle.
REQ-008 in_data  input  CH*DW  one pixel, channel c at bits [c*DW +: DW].
REQ-009 pool_out  output  CH*DW  pooled pixel, same packing as in_data.
REQ-010 relu_3_ready  output  1  one-cycle strobe: pool_out valid this cycle.
REQ-011 pool_done  output  1  one-cycle strobe after the last pooled pixel of an image.

Function
REQ-012 The block SHALL compute 2x2 stride-2 max pooling per channel, giving an (IN_SIZE/2)x(IN_SIZE/2) output (12x12 = 144 pixels at defaults) in raster order.
REQ-013 State machine SHALL have states IDLE, BUSY, DONE; IDLE->BUSY on conv_start; BUSY->DONE when the accepted-pixel count reaches IN_SIZE*IN_SIZE (576); DONE->IDLE after exactly one cycle.
REQ-014 In IDLE and DONE, in_valid SHALL be ignored; in BUSY, conv_start SHALL be ignored.
REQ-015 On entry to BUSY, column counter col, row counter row and output count SHALL be cleared to 0.
REQ-016 Each in_valid cycle in BUSY SHALL advance col; at col = IN_SIZE-1 col wraps to 0 and row increments; cycles without in_valid hold all state (gaps allowed anywhere).
REQ-017 Even col: pixel SHALL be stored in a hold register. Odd col: hmax = per-channel max(hold, in_data).
REQ-018 Even row, odd col: hmax SHALL be written to line buffer entry col>>1 (IN_SIZE/2 entries of CH*DW bits).
REQ-019 Odd row, odd col: pool_out SHALL be registered as per-channel max(line buffer[col>>1], hmax), and relu_3_ready SHALL be 1 for exactly the following cycle.
REQ-020 Latency: relu_3_ready SHALL assert the cycle after the in_valid cycle that accepts the bottom-right pixel of each 2x2 window.
REQ-021 Comparisons SHALL be unsigned and DW bits wide; no carry or saturation needed.
REQ-022 pool_out SHALL hold its last value between strobes.
REQ-023 pool_done SHALL be 1 during the DONE cycle only, i.e. the cycle after the 144th relu_3_ready strobe.
REQ-024 Exactly IN_SIZE*IN_SIZE/4 strobes SHALL be produced per image; extra in_valid after the 576th pixel, in the same cycle as the BUSY->DONE transition or later, SHALL be dropped.
REQ-025 conv_start arriving in DONE SHALL be ignored; the next image needs conv_start in IDLE.

Reset
REQ-026 While rst = 0, the FSM SHALL be in IDLE, counters and hold register 0, pool_out 0, relu_3_ready 0, pool_done 0; line buffer contents need not be reset.
REQ-027 Reset asserted mid-image SHALL abort the image immediately; after release no strobe SHALL appear until a new conv_start and fresh input.

Verification
REQ-028 conv_start, then 576 back-to-back pixels, all channels = (row*24+col) mod 256 -> 144 strobes; first pool_out channel 0 = 25; pool_done one cycle after strobe 144.
REQ-029 Window pixels ch0 = {3,200,7,9}, ch15 = {255,0,0,1} -> pool_out ch0 = 200, ch15 = 255 one cycle after the 4th pixel.
REQ-030 Random in_valid gaps (50% duty) on the REQ-028 image -> identical pool_out sequence, strobe count 144.
REQ-031 rst pulled low after 300 pixels -> outputs 0 immediately; new conv_start + full image -> 144 correct strobes.
REQ-032 in_valid pulsed in IDLE, then conv_start pulsed mid-image -> no strobes in IDLE, second conv_start has no effect, 144 correct strobes.
REQ-033 580 pixels after conv_start -> exactly 144 strobes, single pool_done, FSM back in IDLE.

Source files
------------

// File: rtl/pool_3.sv
// 2x2 stride-2 max pooling over a raster-order stream of IN_SIZE x IN_SIZE pixels.
// Horizontal pairs are merged on odd columns; a half-width line buffer carries even-row results.
module pool_3 #(
    parameter int IN_SIZE = 24,
    parameter int CH      = 16,
    parameter int DW      = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             conv_start,
    input  logic             in_valid,
    input  logic [CH*DW-1:0] in_data,
    output logic [CH*DW-1:0] pool_out,
    output logic             relu_3_ready,
    output logic             pool_done
);
    localparam int W    = CH * DW;
    localparam int CW   = $clog2(IN_SIZE);
    localparam int HALF = IN_SIZE / 2;
    localparam int PW   = $clog2(IN_SIZE * IN_SIZE + 1);
    localparam int OW   = $clog2(IN_SIZE * IN_SIZE / 4 + 1);
    localparam logic [CW-1:0] COL_LAST  = CW'(IN_SIZE - 1);
    localparam logic [PW-1:0] PIX_TOTAL = PW'(IN_SIZE * IN_SIZE);
    localparam logic [OW-1:0] OUT_TOTAL = OW'(IN_SIZE * IN_SIZE / 4);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    function automatic logic [W-1:0] chan_max(input logic [W-1:0] a, input logic [W-1:0] b);
        logic [W-1:0] m;
        m = '0;
        for (int c = 0; c < CH; c++) begin
            m[c*DW +: DW] = (a[c*DW +: DW] >= b[c*DW +: DW]) ? a[c*DW +: DW] : b[c*DW +: DW];
        end
        return m;
    endfunction

    state_t        state_q, state_d;
    logic [CW-1:0] col_q, col_d;
    logic [CW-1:0] row_q, row_d;
    logic [PW-1:0] pix_q, pix_d;
    logic [OW-1:0] outc_q, outc_d;
    logic [W-1:0]  hold_q, hold_d;
    logic [W-1:0]  pool_q, pool_d;
    logic          ready_q, ready_d;
    logic          done_q, done_d;
    logic [W-1:0]  lb_q [HALF];
    logic [W-1:0]  hmax_s;
    logic [W-1:0]  lb_rd_s;
    logic          lb_we_s;

    // Horizontal pair maximum and line-buffer read for the current column pair.
    always_comb begin
        hmax_s  = chan_max(hold_q, in_data);
        lb_rd_s = lb_q[col_q[CW-1:1]];
    end

    // Next-state and datapath control.
    always_comb begin
        state_d = state_q;
        col_d   = col_q;
        row_d   = row_q;
        pix_d   = pix_q;
        outc_d  = outc_q;
        hold_d  = hold_q;
        pool_d  = pool_q;
        ready_d = 1'b0;
        lb_we_s = 1'b0;
        case (state_q)
            IDLE: begin
                if (conv_start) begin
                    state_d = BUSY;
                    col_d   = '0;
                    row_d   = '0;
                    pix_d   = '0;
                    outc_d  = '0;
                end else begin
                    state_d = IDLE;
                end
            end
            BUSY: begin
                // Once the full image is in, this cycle's in_valid is dropped.
                if (pix_q == PIX_TOTAL || outc_q == OUT_TOTAL) begin
                    state_d = DONE;
                end else if (in_valid) begin
                    pix_d = pix_q + PW'(1);
                    if (col_q == COL_LAST) begin
                        col_d = '0;
                        row_d = row_q + CW'(1);
                    end else begin
                        col_d = col_q + CW'(1);
                    end
                    if (!col_q[0]) begin
                        hold_d = in_data;
                    end else if (!row_q[0]) begin
                        lb_we_s = 1'b1;
                    end else begin
                        pool_d  = chan_max(lb_rd_s, hmax_s);
                        ready_d = 1'b1;
                        outc_d  = outc_q + OW'(1);
                    end
                end else begin
                    state_d = BUSY;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
        done_d = (state_d == DONE);
    end

    // Control state and registered outputs.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            col_q   <= '0;
            row_q   <= '0;
            pix_q   <= '0;
            outc_q  <= '0;
            hold_q  <= '0;
            pool_q  <= '0;
            ready_q <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            col_q   <= col_d;
            row_q   <= row_d;
            pix_q   <= pix_d;
            outc_q  <= outc_d;
            hold_q  <= hold_d;
            pool_q  <= pool_d;
            ready_q <= ready_d;
            done_q  <= done_d;
        end
    end

    // Line buffer holds even-row horizontal maxima; contents are don't-care after reset.
    always_ff @(posedge clk) begin
        if (lb_we_s) begin
            lb_q[col_q[CW-1:1]] <= hmax_s;
        end
    end

    assign pool_out     = pool_q;
    assign relu_3_ready = ready_q;
    assign pool_done    = done_q;
endmodule
